instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction assembler and instruction-memory loader. Accepts field-level instruction descriptors over a valid/ready handshake and packs each one into a 32-bit MIPS word. It writes the words to consecutive instruction-memory addresses through a registered, back-pressured write port. Its output is exactly the opcode/funct/field layout that the CPU's control decoder consumes, so test programs and boot images can be generated in hardware.

## Interface
Parameters:
- ADDR_W, 8: word-address width of the instruction memory.
- BASE, 0: word address of the first instruction after `start`.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load at BASE; ignored unless IDLE.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted on the edge where in_valid && in_ready.
- in_last  in  1  descriptor is the final one of the program.
- in_mnem  in  5  mnemonic code (enum in package).
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target field.
- imem_we  out  1  write valid; held until imem_ack.
- imem_ack  in  1  memory accepts the write on the edge where imem_we && imem_ack.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since start.
- done  out  1  one-cycle pulse after the last word is acked.
- wrapped  out  1  sticky; address wrapped past 2^ADDR_W-1.
- err  out  1  sticky; illegal mnemonic seen (only with the macro).

## Operation
- Mnemonic enum: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 jr, 14 jalr, 15 lw, 16 sw, 17 lui, 18 addi, 19 addiu, 20 andi, 21 slti, 22 sltiu, 23 beq, 24 j, 25 jal. Codes 26–31 are illegal.
- R-type: op=0 with rs, rt, rd, shamt, funct.
  - funct values: 20,21,22,23,24,25,26,27,2a,2b,00,02,03,08,09 (hex, enum order).
  - shamt is forced to 0 except for sll/srl/sra.
  - rs is forced to 0 for shifts.
  - jr: only rs is kept.
  - jalr: rs and rd are kept.
- I-type opcodes (hex): 23,2b,0f,08,09,0c,0a,0b,04 with {op, rs, rt, imm}. lui forces rs=0.
- J-type: j=02, jal=03 as {op, target}.
- FSM:
  - IDLE: in_ready=0. `start` loads addr=BASE, count=0, clears wrapped/err, then goes to RUN.
  - RUN: in_ready = !imem_we || imem_ack (one-entry output register). An accepted descriptor is encoded into the output register with the current addr, and addr increments. An accept with in_last goes to DRAIN.
  - DRAIN: in_ready=0; waits for the pending write to be acked, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Address and count:
  - count increments on each imem ack.
  - addr wraps mod 2^ADDR_W. Advancing from 2^ADDR_W-1 sets wrapped.

## Timing
- Reset values: all outputs 0; state IDLE; addr=BASE.
- Latency: a descriptor accepted at edge N appears on imem_* from edge N (visible cycle N+1).
- Throughput: one word per cycle while imem_ack=1.
- imem_addr and imem_wdata are stable while imem_we=1 && !imem_ack.
- Simultaneous ack and new accept on the same edge: the register reloads and imem_we stays 1.
- done is asserted exactly one cycle after the last word is acked.
- `start` outside IDLE has no effect.
- Reset mid-load drops the pending write immediately and returns to IDLE.

## Configuration
- ENC_ILLEGAL_CHECK_EN defined: illegal codes are accepted but not written. err is set, and addr and count are unchanged. in_last on an illegal descriptor still ends the load.
- ENC_ILLEGAL_CHECK_EN undefined: illegal codes encode to 0x00000000 (nop) and are written normally. err is tied to 0.

## Structure
- Package instr_enc_pkg holds:
  - the mnemonic enum;
  - opcode and funct localparams;
  - the FSM state typedef.
- Sub-module instr_pack: a purely combinational encoder from fields to a 32-bit word. The top level holds the FSM, output register and counters.

## Test plan
- start; addi rs=0 rt=8 imm=5, last → word 0x20080005 at addr 0, count=1, done pulses.
- add rs=8 rt=9 rd=10, then sll rt=9 rd=8 shamt=2 with rs=3 → 0x01095020 at addr 0, 0x00094080 at addr 1.
- lw rs=29 rt=8 imm=4, j target=0x0100000, jal target=0x10 → 0x8FA80004, 0x08100000, 0x0C000010 at consecutive addresses.
- imem_ack held low 3 cycles → in_ready=0 and imem_addr/imem_wdata stable; a back-to-back stream with ack=1 gives one write per cycle.
- ADDR_W=2, BASE=3, two words → addresses 3 then 0; wrapped=1.
- Mnemonic 30 with ENC_ILLEGAL_CHECK_EN → no write, err=1, count unchanged; without the macro → 0x00000000 written. reset_n low mid-load → all outputs 0, IDLE.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared definitions for the MIPS instruction assembler / imem loader:
// mnemonic codes, opcode and funct values, field widths, FSM states.
package instr_enc_pkg;

  localparam int unsigned MNEM_W = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 6;

  // Descriptor mnemonic codes; 26..31 are illegal.
  typedef enum logic [MNEM_W-1:0] {
    M_ADD   = 5'd0,  M_ADDU  = 5'd1,  M_SUB   = 5'd2,  M_SUBU  = 5'd3,
    M_AND   = 5'd4,  M_OR    = 5'd5,  M_XOR   = 5'd6,  M_NOR   = 5'd7,
    M_SLT   = 5'd8,  M_SLTU  = 5'd9,  M_SLL   = 5'd10, M_SRL   = 5'd11,
    M_SRA   = 5'd12, M_JR    = 5'd13, M_JALR  = 5'd14, M_LW    = 5'd15,
    M_SW    = 5'd16, M_LUI   = 5'd17, M_ADDI  = 5'd18, M_ADDIU = 5'd19,
    M_ANDI  = 5'd20, M_SLTI  = 5'd21, M_SLTIU = 5'd22, M_BEQ   = 5'd23,
    M_J     = 5'd24, M_JAL   = 5'd25
  } mnem_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0b;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2a;
  localparam logic [OP_W-1:0] FN_SLTU = 6'h2b;
  localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA  = 6'h03;
  localparam logic [OP_W-1:0] FN_JR   = 6'h08;
  localparam logic [OP_W-1:0] FN_JALR = 6'h09;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational MIPS field packer.
// Ports: mnem/rs/rt/rd/shamt/imm/target descriptor fields in;
//        word_c (32-bit encoding, 0 for illegal codes), illegal_c out.
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [MNEM_W-1:0] mnem,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  shamt,
  input  logic [IMM_W-1:0]  imm,
  input  logic [TGT_W-1:0]  target,
  output logic [WORD_W-1:0] word_c,
  output logic              illegal_c
);

  logic [REG_W-1:0] f_rs, f_rt, f_rd, f_sh;
  logic [OP_W-1:0]  funct;
  logic             rtype;

  // R-type field masking is collected first, then one shared R-type pack.
  always_comb begin
    word_c    = '0;
    illegal_c = 1'b0;
    rtype     = 1'b0;
    funct     = '0;
    f_rs      = rs;
    f_rt      = rt;
    f_rd      = rd;
    f_sh      = '0;
    case (mnem)
      M_ADD:   begin rtype = 1'b1; funct = FN_ADD;  end
      M_ADDU:  begin rtype = 1'b1; funct = FN_ADDU; end
      M_SUB:   begin rtype = 1'b1; funct = FN_SUB;  end
      M_SUBU:  begin rtype = 1'b1; funct = FN_SUBU; end
      M_AND:   begin rtype = 1'b1; funct = FN_AND;  end
      M_OR:    begin rtype = 1'b1; funct = FN_OR;   end
      M_XOR:   begin rtype = 1'b1; funct = FN_XOR;  end
      M_NOR:   begin rtype = 1'b1; funct = FN_NOR;  end
      M_SLT:   begin rtype = 1'b1; funct = FN_SLT;  end
      M_SLTU:  begin rtype = 1'b1; funct = FN_SLTU; end
      M_SLL:   begin rtype = 1'b1; funct = FN_SLL; f_rs = '0; f_sh = shamt; end
      M_SRL:   begin rtype = 1'b1; funct = FN_SRL; f_rs = '0; f_sh = shamt; end
      M_SRA:   begin rtype = 1'b1; funct = FN_SRA; f_rs = '0; f_sh = shamt; end
      M_JR:    begin rtype = 1'b1; funct = FN_JR;   f_rt = '0; f_rd = '0; end
      M_JALR:  begin rtype = 1'b1; funct = FN_JALR; f_rt = '0; end
      M_LW:    word_c = {OP_LW,    rs, rt, imm};
      M_SW:    word_c = {OP_SW,    rs, rt, imm};
      M_LUI:   word_c = {OP_LUI,   REG_W'(0), rt, imm};
      M_ADDI:  word_c = {OP_ADDI,  rs, rt, imm};
      M_ADDIU: word_c = {OP_ADDIU, rs, rt, imm};
      M_ANDI:  word_c = {OP_ANDI,  rs, rt, imm};
      M_SLTI:  word_c = {OP_SLTI,  rs, rt, imm};
      M_SLTIU: word_c = {OP_SLTIU, rs, rt, imm};
      M_BEQ:   word_c = {OP_BEQ,   rs, rt, imm};
      M_J:     word_c = {OP_J,   target};
      M_JAL:   word_c = {OP_JAL, target};
      default: illegal_c = 1'b1;
    endcase
    if (rtype) word_c = {OP_RTYPE, f_rs, f_rt, f_rd, f_sh, funct};
  end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction assembler and instruction-memory loader.
// Accepts field descriptors (in_*) over valid/ready, packs them, and writes
// them to consecutive imem addresses from BASE through a one-entry,
// back-pressured write register (imem_we/imem_ack/imem_addr/imem_wdata).
// Status: count (words acked), done (pulse), wrapped (sticky), err (sticky).
// Build option: ENC_ILLEGAL_CHECK_EN drops illegal descriptors and sets err;
// without it illegal codes are written as 0x00000000 and err is 0.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BASE   = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [MNEM_W-1:0]   in_mnem,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_shamt,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [TGT_W-1:0]    in_target,
  output logic                imem_we,
  input  logic                imem_ack,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                done,
  output logic                wrapped,
  output logic                err
);

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] word_c;
  logic              illegal_c;
  logic              accept;
  logic              ack;
  logic              write_ok;

  instr_pack u_pack (
    .mnem      (in_mnem),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .shamt     (in_shamt),
    .imm       (in_imm),
    .target    (in_target),
    .word_c    (word_c),
    .illegal_c (illegal_c)
  );

  // Output register can take a new word when empty or draining this edge.
  assign in_ready = (state == S_RUN) && (!imem_we || imem_ack);
  assign accept   = in_valid && in_ready;
  assign ack      = imem_we && imem_ack;

`ifdef ENC_ILLEGAL_CHECK_EN
  assign write_ok = !illegal_c;

  // Sticky illegal-mnemonic flag, cleared by a new load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if (accept && illegal_c) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal_c;
  assign write_ok       = 1'b1;
  assign err            = 1'b0;
`endif

  // Load FSM, output register, address and count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr       <= ADDR_W'(BASE);
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      done       <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      done <= 1'b0;
      // An ack empties the register; a same-edge accept below reloads it.
      if (ack) begin
        imem_we <= 1'b0;
        count   <= count + (ADDR_W+1)'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            addr    <= ADDR_W'(BASE);
            count   <= '0;
            wrapped <= 1'b0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (write_ok) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr;
              imem_wdata <= word_c;
              addr       <= addr + ADDR_W'(1);
              if (addr == '1) wrapped <= 1'b1;
            end
            if (in_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!imem_we || imem_ack) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected {addr, word}
// entries; monitors pop and compare on every acked imem write.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: ADDR_W=8, BASE=0
  logic        a_start = 0, a_valid = 0, a_last = 0, a_ack = 1;
  logic [4:0]  a_mnem = 0, a_rs = 0, a_rt = 0, a_rd = 0, a_sh = 0;
  logic [15:0] a_imm = 0;
  logic [25:0] a_tgt = 0;
  logic        a_ready, a_we, a_done, a_wrapped, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;

  instr_encoder #(.ADDR_W(8), .BASE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .in_valid(a_valid),
    .in_ready(a_ready), .in_last(a_last), .in_mnem(a_mnem), .in_rs(a_rs),
    .in_rt(a_rt), .in_rd(a_rd), .in_shamt(a_sh), .in_imm(a_imm),
    .in_target(a_tgt), .imem_we(a_we), .imem_ack(a_ack), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .count(a_count), .done(a_done),
    .wrapped(a_wrapped), .err(a_err)
  );

  // Instance B: ADDR_W=2, BASE=3 (wrap case)
  logic        b_start = 0, b_valid = 0, b_last = 0, b_ack = 1;
  logic [4:0]  b_mnem = 0, b_rs = 0, b_rt = 0, b_rd = 0, b_sh = 0;
  logic [15:0] b_imm = 0;
  logic [25:0] b_tgt = 0;
  logic        b_ready, b_we, b_done, b_wrapped, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  instr_encoder #(.ADDR_W(2), .BASE(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .in_valid(b_valid),
    .in_ready(b_ready), .in_last(b_last), .in_mnem(b_mnem), .in_rs(b_rs),
    .in_rt(b_rt), .in_rd(b_rd), .in_shamt(b_sh), .in_imm(b_imm),
    .in_target(b_tgt), .imem_we(b_we), .imem_ack(b_ack), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .count(b_count), .done(b_done),
    .wrapped(b_wrapped), .err(b_err)
  );

  logic [39:0] qa[$];
  logic [33:0] qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitors: one pop per accepted write.
  always @(negedge clk) begin
    if (reset_n && a_we && a_ack) begin
      if (qa.size() == 0) begin
        timeout("a_unexpected_write");
      end else begin
        logic [39:0] e;
        e = qa.pop_front();
        chk("a_addr", 32'(a_addr), 32'(e[39:32]));
        chk("a_wdata", a_wdata, e[31:0]);
      end
    end
    if (reset_n && b_we && b_ack) begin
      if (qb.size() == 0) begin
        timeout("b_unexpected_write");
      end else begin
        logic [33:0] e;
        e = qb.pop_front();
        chk("b_addr", 32'(b_addr), 32'(e[33:32]));
        chk("b_wdata", b_wdata, e[31:0]);
      end
    end
  end

  task automatic drive_a(input logic [4:0] m, rs, rt, rd, sh, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic last, input bit wr,
                         input logic [31:0] w, input logic [7:0] ad);
    a_mnem = m; a_rs = rs; a_rt = rt; a_rd = rd; a_sh = sh;
    a_imm = imm; a_tgt = tgt; a_last = last; a_valid = 1'b1;
    if (wr) qa.push_back({ad, w});
  endtask

  task automatic accept_a(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (a_ready) break;
      waited++;
      if (waited > 40) begin timeout("a_accept"); break; end
    end
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic send_a(input logic [4:0] m, rs, rt, rd, sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last, input bit wr,
                        input logic [31:0] w, input logic [7:0] ad);
    int waited;
    drive_a(m, rs, rt, rd, sh, imm, tgt, last, wr, w, ad);
    accept_a(waited);
  endtask

  task automatic start_a();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int exp_count);
    int n = 0;
    forever begin
      @(negedge clk);
      if (a_done) break;
      n++;
      if (n > 40) begin timeout("a_done"); break; end
    end
    chk("a_count", 32'(a_count), 32'(exp_count));
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    @(negedge clk);
    chk("a_done_pulse", 32'(a_done), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready_b();
    int n = 0;
    forever begin
      @(negedge clk);
      if (b_ready) break;
      n++;
      if (n > 40) begin timeout("b_accept"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'(a_we), 0);
    chk({tag, "_addr"}, 32'(a_addr), 0);
    chk({tag, "_wdata"}, a_wdata, 0);
    chk({tag, "_count"}, 32'(a_count), 0);
    chk({tag, "_done"}, 32'(a_done), 0);
    chk({tag, "_wrapped"}, 32'(a_wrapped), 0);
    chk({tag, "_err"}, 32'(a_err), 0);
    chk({tag, "_ready"}, 32'(a_ready), 0);
    chk({tag, "_b_we"}, 32'(b_we), 0);
    chk({tag, "_b_wrapped"}, 32'(b_wrapped), 0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single addi, last
    start_a();
    send_a(M_ADDI, 0, 8, 0, 0, 16'd5, 0, 1, 1, 32'h20080005, 8'd0);
    wait_done_a(1);

    // add then sll (rs forced 0); a start mid-load must be ignored
    start_a();
    send_a(M_ADD, 8, 9, 10, 0, 0, 0, 0, 1, 32'h01095020, 8'd0);
    start_a();
    send_a(M_SLL, 3, 9, 8, 2, 0, 0, 1, 1, 32'h00094080, 8'd1);
    wait_done_a(2);

    // I-type, J-type and masked R-type forms
    start_a();
    send_a(M_LW,   29, 8, 0, 0, 16'd4, 0, 0, 1, 32'h8FA80004, 8'd0);
    send_a(M_J,    0, 0, 0, 0, 0, 26'h0100000, 0, 1, 32'h08100000, 8'd1);
    send_a(M_JAL,  0, 0, 0, 0, 0, 26'h10, 0, 1, 32'h0C000010, 8'd2);
    send_a(M_LUI,  7, 4, 0, 0, 16'h1234, 0, 0, 1, 32'h3C041234, 8'd3);
    send_a(M_JALR, 2, 3, 31, 0, 0, 0, 0, 1, 32'h0040F809, 8'd4);
    send_a(M_BEQ,  1, 2, 0, 0, 16'hFFFE, 0, 0, 1, 32'h1022FFFE, 8'd5);
    send_a(M_SW,   29, 31, 0, 0, 16'd8, 0, 1, 1, 32'hAFBF0008, 8'd6);
    wait_done_a(7);

    // Back-pressure: hold ack low 3 cycles, then stream at full rate
    start_a();
    a_ack = 1'b0;
    send_a(M_ADDI, 0, 1, 0, 0, 16'd7, 0, 0, 1, 32'h20010007, 8'd0);
    drive_a(M_ANDI, 1, 2, 0, 0, 16'h00FF, 0, 0, 1, 32'h302200FF, 8'd1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 32'(a_ready), 0);
      chk("stall_we", 32'(a_we), 1);
      chk("stall_addr", 32'(a_addr), 0);
      chk("stall_wdata", a_wdata, 32'h20010007);
    end
    @(posedge clk); #1;
    a_ack = 1'b1;
    accept_a(w);
    chk("reload_wait", 32'(w), 0);
    drive_a(M_SUB, 1, 2, 3, 0, 0, 0, 0, 1, 32'h00221822, 8'd2);
    accept_a(w); chk("tput_wait0", 32'(w), 0);
    drive_a(M_XOR, 4, 5, 6, 7, 0, 0, 0, 1, 32'h00853026, 8'd3);
    accept_a(w); chk("tput_wait1", 32'(w), 0);
    drive_a(M_JR, 31, 5, 6, 3, 0, 0, 0, 1, 32'h03E00008, 8'd4);
    accept_a(w); chk("tput_wait2", 32'(w), 0);
    drive_a(M_SRA, 9, 10, 11, 31, 0, 0, 1, 1, 32'h000A5FC3, 8'd5);
    accept_a(w); chk("tput_wait3", 32'(w), 0);
    wait_done_a(6);

    // Illegal mnemonic 30 as the final descriptor
    start_a();
    send_a(M_ADDIU, 2, 3, 0, 0, 16'hFFFF, 0, 0, 1, 32'h2443FFFF, 8'd0);
`ifdef ENC_ILLEGAL_CHECK_EN
    send_a(5'd30, 1, 2, 3, 4, 16'h1111, 0, 1, 0, 32'h0, 8'd0);
    wait_done_a(1);
    chk("illegal_err", 32'(a_err), 1);
`else
    send_a(5'd30, 1, 2, 3, 4, 16'h1111, 0, 1, 1, 32'h00000000, 8'd1);
    wait_done_a(2);
    chk("illegal_err", 32'(a_err), 0);
`endif

    // Reset mid-load drops the pending write
    start_a();
    a_ack = 1'b0;
    send_a(M_ADDI, 0, 8, 0, 0, 16'd5, 0, 0, 0, 32'h20080005, 8'd0);
    a_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    a_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready", 32'(a_ready), 0);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    start_a();
    send_a(M_ADD, 8, 9, 10, 0, 0, 0, 1, 1, 32'h01095020, 8'd0);
    wait_done_a(1);

    // Wrap on the ADDR_W=2, BASE=3 instance
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_mnem = M_ADDI; b_rs = 0; b_rt = 8; b_rd = 0; b_imm = 16'd5;
    b_valid = 1'b1; b_last = 1'b0;
    qb.push_back({2'd3, 32'h20080005});
    wait_ready_b();
    b_mnem = M_ADD; b_rs = 8; b_rt = 9; b_rd = 10; b_imm = 0; b_last = 1'b1;
    qb.push_back({2'd0, 32'h01095020});
    wait_ready_b();
    b_valid = 1'b0; b_last = 1'b0;
    begin
      int n = 0;
      forever begin
        @(negedge clk);
        if (b_done) break;
        n++;
        if (n > 40) begin timeout("b_done"); break; end
      end
    end
    chk("b_wrapped", 32'(b_wrapped), 1);
    chk("b_count", 32'(b_count), 2);
    chk("b_queue_drained", 32'(qb.size()), 0);
    chk("b_err", 32'(b_err), 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
